// File: rtl/id_hazard_regfile_pkg.sv
// Shared types for the decode-stage register file and hazard unit.
// Scoreboard slots carry a fixed-width rd field so the struct can live in a package.
package id_hazard_regfile_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

  localparam logic [5:0] OP_LOAD = 6'h0C;

endpackage

// File: rtl/id_hazard_regfile_if.sv
// Decode-stage bus: instruction fields and write-back port in, operands, stall and stats out.
interface id_hazard_regfile_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 32
);
  import id_hazard_regfile_pkg::*;

  logic                              id_valid;
  logic [NUM_SRC-1:0][REG_AW-1:0]    id_rs;
  logic [NUM_SRC-1:0]                id_rs_used;
  logic [REG_AW-1:0]                 id_rd;
  logic                              id_wr_en;
  logic                              id_is_load;
  logic                              flush;
  logic                              wb_en;
  logic [REG_AW-1:0]                 wb_rd;
  logic [DATA_W-1:0]                 wb_data;
  logic [NUM_SRC-1:0][DATA_W-1:0]    rd_data;
  logic                              id_stall;
  logic                              issue;
  logic [NUM_SRC-1:0][1:0]           fwd_sel;
  logic [CNT_W-1:0]                  stall_cnt;
  logic [CNT_W-1:0]                  hazard_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_wr_en, id_is_load, flush,
           wb_en, wb_rd, wb_data,
    input  rd_data, id_stall, issue, fwd_sel, stall_cnt, hazard_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_wr_en, id_is_load, flush,
           wb_en, wb_rd, wb_data,
    output rd_data, id_stall, issue, fwd_sel, stall_cnt, hazard_cnt
  );

endinterface

// File: rtl/id_hazard_regfile_scoreboard.sv
// In-flight writer scoreboard (EX, MEM, WB slots) with per-operand match, stall and forward-select logic.
module id_hazard_regfile_scoreboard
  import id_hazard_regfile_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FORWARD_EN = 1,
  parameter int ZERO_R0    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue,
  input  logic                           wr_en,
  input  logic                           is_load,
  input  logic [REG_AW-1:0]              rd,
  input  logic [NUM_SRC-1:0][REG_AW-1:0] rs,
  input  logic [NUM_SRC-1:0]             rs_used,
  output logic                           stall_req,
  output logic                           match_any,
  output logic [NUM_SRC-1:0][1:0]        fwd_next
);

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  sb_entry_t          slot [3];
  sb_entry_t          ex_in;
  logic [NUM_SRC-1:0] ex_hit;
  logic [NUM_SRC-1:0] mem_hit;

  always_comb begin
    ex_in         = '0;
    ex_in.valid   = issue & wr_en;
    ex_in.rd      = SB_RD_W'(rd);
    ex_in.is_load = is_load;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 3; s++) slot[s] <= '0;
    end else begin
      slot[SLOT_EX]  <= issue ? ex_in : '0;
      slot[SLOT_MEM] <= slot[SLOT_EX];
      slot[SLOT_WB]  <= slot[SLOT_MEM];
    end
  end

  // A WB-stage writer never matters here: the regfile bypass covers it.
  always_comb begin
    ex_hit  = '0;
    mem_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used[i] && !(ZERO_R0 != 0 && rs[i] == '0)) begin
        ex_hit[i]  = slot[SLOT_EX].valid  && (slot[SLOT_EX].rd  == SB_RD_W'(rs[i]));
        mem_hit[i] = slot[SLOT_MEM].valid && (slot[SLOT_MEM].rd == SB_RD_W'(rs[i]));
      end
    end
  end

  always_comb begin
    stall_req = 1'b0;
    fwd_next  = '0;
    match_any = |(ex_hit | mem_hit);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (FORWARD_EN != 0) begin
        if (ex_hit[i]) begin
          if (slot[SLOT_EX].is_load) stall_req = 1'b1;
          else                       fwd_next[i] = FWD_EXMEM;
        end else if (mem_hit[i]) begin
          fwd_next[i] = FWD_MEMWB;
        end
      end else if (ex_hit[i] || mem_hit[i]) begin
        stall_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_hazard_regfile.sv
// Decode-stage register file with write-back bypass, hazard stall/issue control,
// registered forward selects and saturating stall/hazard statistics.
module id_hazard_regfile
  import id_hazard_regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_NUM    = 32,
  parameter int REG_AW     = $clog2(REG_NUM),
  parameter int NUM_SRC    = 2,
  parameter int FORWARD_EN = 1,
  parameter int ZERO_R0    = 0,
  parameter int CNT_W      = 32
) (
  input logic                clk,
  input logic                rst,
  id_hazard_regfile_if.slave bus
);

  logic [DATA_W-1:0]              regs [REG_NUM];
  logic [NUM_SRC-1:0][DATA_W-1:0] rd_data;
  logic [NUM_SRC-1:0][1:0]        fwd_next;
  logic [NUM_SRC-1:0][1:0]        fwd_sel;
  logic [CNT_W-1:0]               stall_cnt;
  logic [CNT_W-1:0]               hazard_cnt;
  logic                           stall_req;
  logic                           match_any;
  logic                           id_stall;
  logic                           issue;
  logic                           wr_ok;
  logic                           hazard_seen;

  id_hazard_regfile_scoreboard #(
    .REG_AW    (REG_AW),
    .NUM_SRC   (NUM_SRC),
    .FORWARD_EN(FORWARD_EN),
    .ZERO_R0   (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .wr_en    (bus.id_wr_en),
    .is_load  (bus.id_is_load),
    .rd       (bus.id_rd),
    .rs       (bus.id_rs),
    .rs_used  (bus.id_rs_used),
    .stall_req(stall_req),
    .match_any(match_any),
    .fwd_next (fwd_next)
  );

  // Gating with rst keeps stall/issue low for as long as reset is held.
  assign id_stall = rst && bus.id_valid && stall_req && !bus.flush;
  assign issue    = rst && bus.id_valid && !id_stall && !bus.flush;
  assign wr_ok    = bus.wb_en && !(ZERO_R0 != 0 && bus.wb_rd == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ZERO_R0 != 0 && bus.id_rs[i] == '0)         rd_data[i] = '0;
      else if (bus.wb_en && bus.wb_rd == bus.id_rs[i]) rd_data[i] = bus.wb_data;
      else                                             rd_data[i] = regs[bus.id_rs[i]];
    end
  end

  // hazard_seen makes one instruction count once however long it waits in ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_sel     <= '0;
      stall_cnt   <= '0;
      hazard_cnt  <= '0;
      hazard_seen <= 1'b0;
    end else begin
      fwd_sel <= issue ? fwd_next : '0;
      if (id_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (bus.id_valid && match_any && !hazard_seen && hazard_cnt != '1)
        hazard_cnt <= hazard_cnt + CNT_W'(1);
      if (issue || bus.flush)
        hazard_seen <= 1'b0;
      else if (bus.id_valid && match_any)
        hazard_seen <= 1'b1;
    end
  end

  assign bus.rd_data    = rd_data;
  assign bus.id_stall   = id_stall;
  assign bus.issue      = issue;
  assign bus.fwd_sel    = fwd_sel;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.hazard_cnt = hazard_cnt;

endmodule

// File: tb/tb_id_hazard_regfile.sv
// Directed bench: a forwarding instance (dut_f) and a non-forwarding, zero-r0,
// 3-bit-counter instance (dut_n) exercised in turn.
module tb_id_hazard_regfile;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  id_hazard_regfile_if #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2), .CNT_W(32)) f_if ();
  id_hazard_regfile_if #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2), .CNT_W(3))  n_if ();

  id_hazard_regfile #(.FORWARD_EN(1), .ZERO_R0(0), .CNT_W(32)) dut_f (
    .clk(clk), .rst(rst), .bus(f_if.slave));

  id_hazard_regfile #(.FORWARD_EN(0), .ZERO_R0(1), .CNT_W(3)) dut_n (
    .clk(clk), .rst(rst), .bus(n_if.slave));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd,
                         input logic wr, input logic ld);
    f_if.id_valid   = v;
    f_if.id_rs[0]   = rs0;
    f_if.id_rs[1]   = rs1;
    f_if.id_rs_used = used;
    f_if.id_rd      = rd;
    f_if.id_wr_en   = wr;
    f_if.id_is_load = ld;
  endtask

  task automatic drive_n(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd,
                         input logic wr, input logic ld);
    n_if.id_valid   = v;
    n_if.id_rs[0]   = rs0;
    n_if.id_rs[1]   = rs1;
    n_if.id_rs_used = used;
    n_if.id_rd      = rd;
    n_if.id_wr_en   = wr;
    n_if.id_is_load = ld;
  endtask

  task automatic test_reset();
    #3;
    total++; if (f_if.issue !== 1'b0) begin bad++; $display("[TB] FAIL rst_issue got=%0b want=0", f_if.issue); end
    total++; if (f_if.id_stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall got=%0b want=0", f_if.id_stall); end
    total++; if (f_if.fwd_sel !== 4'h0) begin bad++; $display("[TB] FAIL rst_fwd got=%0h want=0", f_if.fwd_sel); end
    total++; if (f_if.stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL rst_stall_cnt got=%0d want=0", f_if.stall_cnt); end
    total++; if (n_if.hazard_cnt !== 3'd0) begin bad++; $display("[TB] FAIL rst_hazard_cnt got=%0d want=0", n_if.hazard_cnt); end
    rst = 1'b1;
    drive_f(0, 0, 0, 2'b00, 0, 0, 0);
    cyc();
  endtask

  task automatic test_fwd_back_to_back();
    drive_f(1, 1, 2, 2'b11, 3, 1, 0);
    #1;
    total++; if (f_if.issue !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first_issue got=%0b want=1", f_if.issue); end
    cyc();
    drive_f(1, 3, 1, 2'b11, 4, 1, 0);
    #1;
    total++; if (f_if.id_stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stall got=%0b want=0", f_if.id_stall); end
    total++; if (f_if.issue !== 1'b1) begin bad++; $display("[TB] FAIL b2b_issue got=%0b want=1", f_if.issue); end
    cyc();
    drive_f(0, 0, 0, 2'b00, 0, 0, 0);
    total++; if (f_if.fwd_sel !== 4'b0001) begin bad++; $display("[TB] FAIL b2b_fwd got=%0h want=1", f_if.fwd_sel); end
    total++; if (f_if.hazard_cnt !== 32'd1) begin bad++; $display("[TB] FAIL b2b_hazard_cnt got=%0d want=1", f_if.hazard_cnt); end
    cyc();
    total++; if (f_if.fwd_sel !== 4'b0000) begin bad++; $display("[TB] FAIL b2b_fwd_bubble got=%0h want=0", f_if.fwd_sel); end
    cyc(); cyc();
  endtask

  task automatic test_load_use();
    drive_f(1, 1, 0, 2'b01, 5, 1, 1);
    cyc();
    drive_f(1, 5, 5, 2'b11, 6, 1, 0);
    #1;
    total++; if (f_if.id_stall !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%0b want=1", f_if.id_stall); end
    total++; if (f_if.issue !== 1'b0) begin bad++; $display("[TB] FAIL lu_issue got=%0b want=0", f_if.issue); end
    cyc();
    total++; if (f_if.stall_cnt !== 32'd1) begin bad++; $display("[TB] FAIL lu_stall_cnt got=%0d want=1", f_if.stall_cnt); end
    #1;
    total++; if (f_if.id_stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall2 got=%0b want=0", f_if.id_stall); end
    total++; if (f_if.issue !== 1'b1) begin bad++; $display("[TB] FAIL lu_issue2 got=%0b want=1", f_if.issue); end
    cyc();
    drive_f(0, 0, 0, 2'b00, 0, 0, 0);
    total++; if (f_if.fwd_sel !== 4'b1010) begin bad++; $display("[TB] FAIL lu_fwd got=%0h want=a", f_if.fwd_sel); end
    total++; if (f_if.stall_cnt !== 32'd1) begin bad++; $display("[TB] FAIL lu_stall_cnt_after got=%0d want=1", f_if.stall_cnt); end
    total++; if (f_if.hazard_cnt !== 32'd2) begin bad++; $display("[TB] FAIL lu_hazard_cnt got=%0d want=2", f_if.hazard_cnt); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_wb_bypass();
    f_if.wb_en   = 1'b1;
    f_if.wb_rd   = 5'd7;
    f_if.wb_data = 32'hDEADBEEF;
    drive_f(1, 7, 3, 2'b11, 8, 0, 0);
    #1;
    total++; if (f_if.rd_data[0] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL bypass_rd0 got=%0h want=deadbeef", f_if.rd_data[0]); end
    total++; if (f_if.rd_data[1] !== 32'h0) begin bad++; $display("[TB] FAIL bypass_rd1 got=%0h want=0", f_if.rd_data[1]); end
    cyc();
    f_if.wb_en = 1'b0;
    drive_f(0, 7, 3, 2'b11, 8, 0, 0);
    #1;
    total++; if (f_if.rd_data[0] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL stored_rd0 got=%0h want=deadbeef", f_if.rd_data[0]); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_flush_stall();
    drive_f(1, 1, 0, 2'b01, 5, 1, 1);
    cyc();
    drive_f(1, 5, 5, 2'b11, 6, 1, 0);
    #1;
    total++; if (f_if.id_stall !== 1'b1) begin bad++; $display("[TB] FAIL fl_pre_stall got=%0b want=1", f_if.id_stall); end
    f_if.flush = 1'b1;
    #1;
    total++; if (f_if.id_stall !== 1'b0) begin bad++; $display("[TB] FAIL fl_stall got=%0b want=0", f_if.id_stall); end
    total++; if (f_if.issue !== 1'b0) begin bad++; $display("[TB] FAIL fl_issue got=%0b want=0", f_if.issue); end
    cyc();
    f_if.flush = 1'b0;
    total++; if (f_if.stall_cnt !== 32'd1) begin bad++; $display("[TB] FAIL fl_stall_cnt got=%0d want=1", f_if.stall_cnt); end
    total++; if (f_if.hazard_cnt !== 32'd3) begin bad++; $display("[TB] FAIL fl_hazard_cnt got=%0d want=3", f_if.hazard_cnt); end
    // Reading r6 next: the flushed add must not sit in EX.
    drive_f(1, 6, 0, 2'b01, 9, 1, 0);
    #1;
    total++; if (f_if.issue !== 1'b1) begin bad++; $display("[TB] FAIL fl_next_issue got=%0b want=1", f_if.issue); end
    cyc();
    drive_f(0, 0, 0, 2'b00, 0, 0, 0);
    total++; if (f_if.fwd_sel !== 4'b0000) begin bad++; $display("[TB] FAIL fl_ex_empty got=%0h want=0", f_if.fwd_sel); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_zero_r0();
    n_if.wb_en   = 1'b1;
    n_if.wb_rd   = 5'd0;
    n_if.wb_data = 32'd5;
    drive_n(0, 0, 0, 2'b00, 0, 0, 0);
    #1;
    total++; if (n_if.rd_data[0] !== 32'd0) begin bad++; $display("[TB] FAIL r0_bypass got=%0h want=0", n_if.rd_data[0]); end
    cyc();
    n_if.wb_en = 1'b0;
    #1;
    total++; if (n_if.rd_data[0] !== 32'd0) begin bad++; $display("[TB] FAIL r0_stored got=%0h want=0", n_if.rd_data[0]); end
  endtask

  task automatic test_nofwd_adjacent();
    drive_n(1, 1, 2, 2'b11, 3, 1, 0);
    cyc();
    drive_n(1, 3, 2, 2'b11, 4, 1, 0);
    #1;
    total++; if (n_if.id_stall !== 1'b1) begin bad++; $display("[TB] FAIL nf_adj_stall1 got=%0b want=1", n_if.id_stall); end
    cyc();
    total++; if (n_if.hazard_cnt !== 3'd1) begin bad++; $display("[TB] FAIL nf_adj_hazard got=%0d want=1", n_if.hazard_cnt); end
    #1;
    total++; if (n_if.id_stall !== 1'b1) begin bad++; $display("[TB] FAIL nf_adj_stall2 got=%0b want=1", n_if.id_stall); end
    cyc();
    #1;
    total++; if (n_if.issue !== 1'b1) begin bad++; $display("[TB] FAIL nf_adj_issue got=%0b want=1", n_if.issue); end
    cyc();
    drive_n(0, 0, 0, 2'b00, 0, 0, 0);
    total++; if (n_if.stall_cnt !== 3'd2) begin bad++; $display("[TB] FAIL nf_adj_stall_cnt got=%0d want=2", n_if.stall_cnt); end
    total++; if (n_if.hazard_cnt !== 3'd1) begin bad++; $display("[TB] FAIL nf_adj_hazard_end got=%0d want=1", n_if.hazard_cnt); end
    total++; if (n_if.fwd_sel !== 4'b0000) begin bad++; $display("[TB] FAIL nf_adj_fwd got=%0h want=0", n_if.fwd_sel); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_nofwd_distance2();
    drive_n(1, 1, 2, 2'b11, 3, 1, 0);
    cyc();
    drive_n(1, 1, 2, 2'b11, 9, 1, 0);
    cyc();
    drive_n(1, 3, 2, 2'b11, 4, 1, 0);
    #1;
    total++; if (n_if.id_stall !== 1'b1) begin bad++; $display("[TB] FAIL nf_d2_stall got=%0b want=1", n_if.id_stall); end
    cyc();
    #1;
    total++; if (n_if.issue !== 1'b1) begin bad++; $display("[TB] FAIL nf_d2_issue got=%0b want=1", n_if.issue); end
    cyc();
    drive_n(0, 0, 0, 2'b00, 0, 0, 0);
    total++; if (n_if.stall_cnt !== 3'd3) begin bad++; $display("[TB] FAIL nf_d2_stall_cnt got=%0d want=3", n_if.stall_cnt); end
    total++; if (n_if.hazard_cnt !== 3'd2) begin bad++; $display("[TB] FAIL nf_d2_hazard got=%0d want=2", n_if.hazard_cnt); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_immediate();
    drive_n(1, 1, 2, 2'b11, 3, 1, 0);
    cyc();
    drive_n(1, 1, 3, 2'b01, 4, 1, 0);
    #1;
    total++; if (n_if.id_stall !== 1'b0) begin bad++; $display("[TB] FAIL imm_stall got=%0b want=0", n_if.id_stall); end
    total++; if (n_if.issue !== 1'b1) begin bad++; $display("[TB] FAIL imm_issue got=%0b want=1", n_if.issue); end
    cyc();
    drive_n(0, 0, 0, 2'b00, 0, 0, 0);
    cyc(); cyc(); cyc();
  endtask

  task automatic test_saturation();
    logic [2:0] exp_stall [3];
    exp_stall[0] = 3'd5;
    exp_stall[1] = 3'd7;
    exp_stall[2] = 3'd7;
    for (int p = 0; p < 3; p++) begin
      drive_n(1, 1, 2, 2'b11, 3, 1, 0);
      cyc();
      drive_n(1, 3, 2, 2'b11, 4, 1, 0);
      cyc(); cyc(); cyc();
      total++;
      if (n_if.stall_cnt !== exp_stall[p]) begin
        bad++; $display("[TB] FAIL sat_stall_cnt pair=%0d got=%0d want=%0d", p, n_if.stall_cnt, exp_stall[p]);
      end
    end
    drive_n(0, 0, 0, 2'b00, 0, 0, 0);
    total++; if (n_if.hazard_cnt !== 3'd5) begin bad++; $display("[TB] FAIL sat_hazard_cnt got=%0d want=5", n_if.hazard_cnt); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset_mid_stall();
    f_if.wb_en   = 1'b1;
    f_if.wb_rd   = 5'd5;
    f_if.wb_data = 32'h55;
    cyc();
    f_if.wb_en = 1'b0;
    drive_f(1, 1, 0, 2'b01, 5, 1, 1);
    cyc();
    drive_f(1, 5, 5, 2'b11, 6, 1, 0);
    #1;
    total++; if (f_if.id_stall !== 1'b1) begin bad++; $display("[TB] FAIL rms_pre_stall got=%0b want=1", f_if.id_stall); end
    total++; if (f_if.rd_data[0] !== 32'h55) begin bad++; $display("[TB] FAIL rms_pre_r5 got=%0h want=55", f_if.rd_data[0]); end
    rst = 1'b0;
    #1;
    total++; if (f_if.id_stall !== 1'b0) begin bad++; $display("[TB] FAIL rms_stall got=%0b want=0", f_if.id_stall); end
    total++; if (f_if.issue !== 1'b0) begin bad++; $display("[TB] FAIL rms_issue got=%0b want=0", f_if.issue); end
    total++; if (f_if.stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL rms_stall_cnt got=%0d want=0", f_if.stall_cnt); end
    total++; if (f_if.hazard_cnt !== 32'd0) begin bad++; $display("[TB] FAIL rms_hazard_cnt got=%0d want=0", f_if.hazard_cnt); end
    total++; if (f_if.fwd_sel !== 4'h0) begin bad++; $display("[TB] FAIL rms_fwd got=%0h want=0", f_if.fwd_sel); end
    total++; if (f_if.rd_data[0] !== 32'h0) begin bad++; $display("[TB] FAIL rms_r5 got=%0h want=0", f_if.rd_data[0]); end
    cyc();
    total++; if (f_if.issue !== 1'b0) begin bad++; $display("[TB] FAIL rms_issue_held got=%0b want=0", f_if.issue); end
    rst = 1'b1;
    drive_f(0, 0, 0, 2'b00, 0, 0, 0);
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    drive_f(1, 0, 0, 2'b00, 0, 0, 0);
    drive_n(0, 0, 0, 2'b00, 0, 0, 0);
    f_if.flush = 1'b0; f_if.wb_en = 1'b0; f_if.wb_rd = '0; f_if.wb_data = '0;
    n_if.flush = 1'b0; n_if.wb_en = 1'b0; n_if.wb_rd = '0; n_if.wb_data = '0;

    test_reset();
    test_fwd_back_to_back();
    test_load_use();
    test_wb_bypass();
    test_flush_stall();
    test_zero_r0();
    test_nofwd_adjacent();
    test_nofwd_distance2();
    test_immediate();
    test_saturation();
    test_reset_mid_stall();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_hazard_regfile.md
# id_hazard_regfile

Parametrised decode-stage register file and hazard unit for the MIPS-lite pipeline, sitting between IF/ID and ID/EX. It provides multi-port register reads with write-back bypass, tracks in-flight writers in a shift-register scoreboard, and generates per-operand forward selects. It stalls only for load-use hazards (forwarding build) or for any RAW within two stages (non-forwarding build). Stall and hazard statistics are exposed as saturating counter ports instead of globals.

## Interface
- DATA_W, 32, register data width
- REG_NUM, 32, number of architectural registers
- REG_AW, $clog2(REG_NUM), register index width
- NUM_SRC, 2, source operands read per instruction
- FORWARD_EN, 1, 1 = EX/MEM forwarding with load-use stall; 0 = stall on any EX/MEM RAW
- ZERO_R0, 0, 1 = register 0 reads 0 and ignores writes
- CNT_W, 32, statistics counter width
- clk  in  1  clock, all state on posedge
- rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  NUM_SRC×REG_AW  source register indices
- id_rs_used  in  NUM_SRC  source actually read (immediate forms clear bit 1)
- id_rd  in  REG_AW  destination index
- id_wr_en  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load (opcode 0x0C)
- flush  in  1  branch taken: kill ID instruction this cycle
- wb_en, wb_rd, wb_data  in  1 / REG_AW / DATA_W  write-back port
- rd_data  out  NUM_SRC×DATA_W  combinational operand values
- id_stall  out  1  hold PC and IF/ID
- issue  out  1  instruction enters EX this cycle
- fwd_sel  out  NUM_SRC×2  registered: 0 regfile, 1 EX/MEM reg, 2 MEM/WB reg
- stall_cnt, hazard_cnt  out  CNT_W  statistics

## Operation
- Regfile: write on posedge when wb_en (suppressed for index 0 if ZERO_R0). rd_data[i] = wb_data if wb_en and wb_rd==id_rs[i] (bypass), else stored value; 0 for index 0 if ZERO_R0.
- Scoreboard: three slots {valid, rd, is_load} for EX, MEM, WB. Each posedge shifts EX→MEM→WB; the EX slot loads {id_wr_en, id_rd, id_is_load} when issue, else a bubble (valid=0).
- Match on operand i: id_rs_used[i] and slot valid and slot.rd==id_rs[i] (never for index 0 when ZERO_R0). EX slot takes priority over MEM; a WB match needs nothing (bypass).
- FORWARD_EN=1: EX match with is_load → stall; EX match otherwise → next fwd_sel=1; MEM match → next fwd_sel=2.
- FORWARD_EN=0: any EX or MEM match → stall; fwd_sel stays 0.
- id_stall = id_valid & any stall condition & !flush. issue = id_valid & !id_stall & !flush.
- fwd_sel registers the computed value on issue; otherwise registers 0 (bubble).
- stall_cnt +1 every cycle id_stall=1. hazard_cnt +1 once per instruction, on the first cycle an EX/MEM match exists (a sticky flag cleared on issue or flush). Both saturate at all-ones.

## Timing
- Asynchronous reset (rst=0): regfile, scoreboard, fwd_sel, counters and the hazard flag go to 0 immediately; id_stall and issue are 0 while reset is held. Reset mid-stall discards the stall.
- rd_data, id_stall and issue are same-cycle combinational; fwd_sel is valid in the cycle the consumer is in EX.
- Load-use with forwarding: 1 stall cycle, then fwd_sel=2. Non-forwarding: 2 stall cycles after an adjacent producer, 1 cycle at distance 2.
- flush overrides stall in the same cycle; the scoreboard receives a bubble.
- Simultaneous WB write and read of the same register returns the new data.

## Structure
- mipspkg TYPES additions: fwd_sel_e enum (FWD_RF, FWD_EXMEM, FWD_MEMWB), sb_entry_t struct {valid, rd, is_load}, opcode constant OP_LOAD=6'h0C.
- One sub-module: hazard_scoreboard (slot shift register plus match/priority logic). The regfile and counters stay in the top module.

## Test plan
- Reset mid-stall: load r5; stall; pull rst low → id_stall=0, stall_cnt=0, fwd_sel=0, and r5 reads 0.
- FORWARD_EN=1: add r3 then add r4,r3,r1 back-to-back → no stall, fwd_sel[0]=1 in the next cycle, hazard_cnt=1.
- Load r5 then add r6,r5,r5 → id_stall=1 for exactly 1 cycle, stall_cnt=1, fwd_sel={2,2} on issue.
- FORWARD_EN=0: add r3 then sub r4,r3,r2 → 2 stall cycles, stall_cnt=2, hazard_cnt=1, fwd_sel=0.
- WB write r7=0xDEADBEEF while ID reads r7 → rd_data[0]=0xDEADBEEF in the same cycle. With ZERO_R0=1, writing r0=5 still reads 0.
- flush asserted during a load-use stall → id_stall=0, issue=0, EX slot empty next cycle, stall_cnt frozen.
